fft_mag_peak: RTL and testbench

Downstream stage of the FFT datapath. Accepts complex single-precision IEEE-754 bins (real, imaginary) in frame order and computes the squared magnitude re²+im² of each bin. It buffers results in an output FIFO under valid/ready flow control. It also reports, once per frame, the largest squared magnitude and its bin index.

---
 rtl/fft_mag_peak.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_fft_mag_peak.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_peak.sv
//==============================================================================
// Module   : fft_mag_peak
// Purpose  : Squared magnitude of complex FP32 bins with output FIFO and per-frame peak.
// Revision : 1.0
//==============================================================================
`default_nettype none

// FP32 multiplier core (RNE, subnormals flushed to zero), fixed latency LAT >= 1.
module fft_mag_peak_fpmul #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
  logic        [47:0] w_prod;
  logic        [23:0] w_m24;
  logic        [24:0] w_m;
  logic               w_g, w_st, w_inc;
  logic signed [10:0] w_e;
  logic        [31:0] w_res;
  logic        [31:0] r_pipe [LAT];

  always_comb begin
    w_a_nan  = (&a[30:23]) && (|a[22:0]);
    w_b_nan  = (&b[30:23]) && (|b[22:0]);
    w_a_inf  = (&a[30:23]) && !(|a[22:0]);
    w_b_inf  = (&b[30:23]) && !(|b[22:0]);
    w_a_zero = !(|a[30:23]);
    w_b_zero = !(|b[30:23]);
    w_sign   = a[31] ^ b[31];
    w_prod   = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    w_e      = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127
             + (w_prod[47] ? 11'sd1 : 11'sd0);
    if (w_prod[47]) begin
      w_m24 = w_prod[47:24];
      w_g   = w_prod[23];
      w_st  = |w_prod[22:0];
    end else begin
      w_m24 = w_prod[46:23];
      w_g   = w_prod[22];
      w_st  = |w_prod[21:0];
    end
    w_inc = w_g & (w_st | w_m24[0]);
    w_m   = {1'b0, w_m24} + {24'h0, w_inc};
    if (w_m[24]) begin
      w_m = w_m >> 1;
      w_e = w_e + 11'sd1;
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_res = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      w_res = {w_sign, 8'hFF, 23'h0};
    else if (w_a_zero || w_b_zero || (w_e <= 11'sd0))
      w_res = {w_sign, 31'h0};
    else if (w_e >= 11'sd255)
      w_res = {w_sign, 8'hFF, 23'h0};
    else
      w_res = {w_sign, w_e[7:0], w_m[22:0]};
  end

  always_ff @(posedge clk) r_pipe[0] <= w_res;

  for (genvar i = 1; i < LAT; i++) begin : g_stage
    always_ff @(posedge clk) r_pipe[i] <= r_pipe[i-1];
  end

  assign y = r_pipe[LAT-1];
endmodule

// FP32 adder core (RNE, subnormals flushed to zero), fixed latency LAT >= 1.
module fft_mag_peak_fpadd #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        [31:0] w_big, w_sml, w_res;
  logic         [7:0] w_d;
  logic        [26:0] w_mb, w_ms_full, w_ms;
  logic        [27:0] w_s;
  logic        [24:0] w_m;
  logic               w_g, w_st, w_inc;
  logic signed [10:0] w_e;
  logic        [31:0] r_pipe [LAT];

  always_comb begin
    w_a_nan  = (&a[30:23]) && (|a[22:0]);
    w_b_nan  = (&b[30:23]) && (|b[22:0]);
    w_a_inf  = (&a[30:23]) && !(|a[22:0]);
    w_b_inf  = (&b[30:23]) && !(|b[22:0]);
    w_a_zero = !(|a[30:23]);
    w_b_zero = !(|b[30:23]);
    if (a[30:0] >= b[30:0]) begin
      w_big = a;
      w_sml = b;
    end else begin
      w_big = b;
      w_sml = a;
    end
    w_d       = w_big[30:23] - w_sml[30:23];
    w_mb      = {1'b1, w_big[22:0], 3'b000};
    w_ms_full = {1'b1, w_sml[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky bit.
    if (w_d >= 8'd27)
      w_ms = 27'd1;
    else begin
      w_ms    = w_ms_full >> w_d;
      w_ms[0] = w_ms[0] | (|(w_ms_full & ~(27'h7FF_FFFF << w_d)));
    end
    w_e = $signed({3'b000, w_big[30:23]});
    if (w_big[31] == w_sml[31]) begin
      w_s = {1'b0, w_mb} + {1'b0, w_ms};
      if (w_s[27]) begin
        w_s = {1'b0, w_s[27:2], w_s[1] | w_s[0]};
        w_e = w_e + 11'sd1;
      end
    end else begin
      w_s = {1'b0, w_mb} - {1'b0, w_ms};
      for (int i = 0; i < 26; i++) begin
        if (!w_s[26] && (w_s != 28'h0)) begin
          w_s = w_s << 1;
          w_e = w_e - 11'sd1;
        end
      end
    end
    w_g   = w_s[2];
    w_st  = |w_s[1:0];
    w_inc = w_g & (w_st | w_s[3]);
    w_m   = {1'b0, w_s[26:3]} + {24'h0, w_inc};
    if (w_m[24]) begin
      w_m = w_m >> 1;
      w_e = w_e + 11'sd1;
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31])))
      w_res = 32'h7FC0_0000;
    else if (w_a_inf)
      w_res = a;
    else if (w_b_inf)
      w_res = b;
    else if (w_a_zero && w_b_zero)
      w_res = {a[31] & b[31], 31'h0};
    else if (w_a_zero)
      w_res = b;
    else if (w_b_zero)
      w_res = a;
    else if ((w_s == 28'h0) || (w_e <= 11'sd0))
      w_res = 32'h0;
    else if (w_e >= 11'sd255)
      w_res = {w_big[31], 8'hFF, 23'h0};
    else
      w_res = {w_big[31], w_e[7:0], w_m[22:0]};
  end

  always_ff @(posedge clk) r_pipe[0] <= w_res;

  for (genvar i = 1; i < LAT; i++) begin : g_stage
    always_ff @(posedge clk) r_pipe[i] <= r_pipe[i-1];
  end

  assign y = r_pipe[LAT-1];
endmodule

module fft_mag_peak #(
  parameter int MUL_LAT    = 6,
  parameter int ADD_LAT    = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_re,
  input  logic [31:0]      in_im,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_mag,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             peak_valid,
  output logic [31:0]      peak_mag,
  output logic [IDX_W-1:0] peak_idx,
  output logic             nan_seen
);
  localparam int c_lat = MUL_LAT + ADD_LAT;
  localparam int c_aw  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw  = $clog2(FIFO_DEPTH + c_lat + 1) + 1;
  localparam int c_ew  = 1 + IDX_W + 32;
  localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_last = c_aw'(FIFO_DEPTH - 1);

  logic             w_acc, w_fend, w_push, w_pop, w_ex_nan, w_upd;
  logic [31:0]      w_rr, w_ii, w_ex_mag, w_pk_mag;
  logic [IDX_W-1:0] w_pk_idx;
  logic [c_cw-1:0]  w_inflight;
  logic [c_ew-1:0]  w_head;

  logic [IDX_W-1:0] r_idx;
  logic [c_lat-1:0] r_sb_v, r_sb_last;
  logic [IDX_W-1:0] r_sb_idx [c_lat];
  logic [c_ew-1:0]  r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wp, r_rp;
  logic [c_cw-1:0]  r_count;
  logic             r_have, r_pk_nan;
  logic [31:0]      r_pk_mag;
  logic [IDX_W-1:0] r_pk_idx;

  fft_mag_peak_fpmul #(.LAT(MUL_LAT)) u_mul_re (.clk(clk), .a(in_re), .b(in_re), .y(w_rr));
  fft_mag_peak_fpmul #(.LAT(MUL_LAT)) u_mul_im (.clk(clk), .a(in_im), .b(in_im), .y(w_ii));
  fft_mag_peak_fpadd #(.LAT(ADD_LAT)) u_add    (.clk(clk), .a(w_rr),  .b(w_ii),  .y(w_ex_mag));

  // Credit covers every bin already committed to a FIFO slot, so pushes never overflow.
  assign w_inflight = c_cw'($countones(r_sb_v));
  assign in_ready   = (r_count + w_inflight) < c_depth;
  assign w_acc      = in_valid && in_ready;
  assign w_fend     = in_last || (r_idx == {IDX_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_sb_v    <= '0;
      r_sb_last <= '0;
      for (int i = 0; i < c_lat; i++) r_sb_idx[i] <= '0;
    end else begin
      if (w_acc) r_idx <= w_fend ? '0 : r_idx + 1'b1;
      // Frame end (explicit or forced) travels as the single last flag.
      r_sb_v      <= {r_sb_v[c_lat-2:0], w_acc};
      r_sb_last   <= {r_sb_last[c_lat-2:0], w_acc && w_fend};
      r_sb_idx[0] <= r_idx;
      for (int i = 1; i < c_lat; i++) r_sb_idx[i] <= r_sb_idx[i-1];
    end
  end

  assign w_push    = r_sb_v[c_lat-1];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rp];
  assign out_mag   = out_valid ? w_head[31:0] : 32'h0;
  assign out_idx   = out_valid ? w_head[IDX_W+31:32] : '0;
  assign out_last  = out_valid && w_head[c_ew-1];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_sb_last[c_lat-1], r_sb_idx[c_lat-1], w_ex_mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == c_ptr_last) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == c_ptr_last) ? '0 : r_rp + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_ex_nan = (&w_ex_mag[30:23]) && (|w_ex_mag[22:0]);
  assign w_upd    = w_push && !w_ex_nan && (!r_have || (w_ex_mag[30:0] > r_pk_mag[30:0]));
  assign w_pk_mag = w_upd ? w_ex_mag : r_pk_mag;
  assign w_pk_idx = w_upd ? r_sb_idx[c_lat-1] : r_pk_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_have     <= 1'b0;
      r_pk_nan   <= 1'b0;
      r_pk_mag   <= '0;
      r_pk_idx   <= '0;
      peak_valid <= 1'b0;
      peak_mag   <= '0;
      peak_idx   <= '0;
      nan_seen   <= 1'b0;
    end else begin
      peak_valid <= w_push && r_sb_last[c_lat-1];
      if (w_push) begin
        if (r_sb_last[c_lat-1]) begin
          peak_mag <= w_pk_mag;
          peak_idx <= w_pk_idx;
          nan_seen <= r_pk_nan | w_ex_nan;
          r_have   <= 1'b0;
          r_pk_nan <= 1'b0;
          r_pk_mag <= '0;
          r_pk_idx <= '0;
        end else begin
          r_have   <= r_have | w_upd;
          r_pk_nan <= r_pk_nan | w_ex_nan;
          r_pk_mag <= w_pk_mag;
          r_pk_idx <= w_pk_idx;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fft_mag_peak.sv
//==============================================================================
// Module   : tb_fft_mag_peak
// Purpose  : Directed vector table, corner sequences and random frames vs. reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_fft_mag_peak;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready;
  logic [31:0] in_re = '0, in_im = '0;
  logic        in_ready, out_valid, out_last, peak_valid, nan_seen;
  logic [31:0] out_mag, peak_mag;
  logic [7:0]  out_idx, peak_idx;

  fft_mag_peak dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re),
    .in_im(in_im), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_idx(out_idx), .out_last(out_last), .peak_valid(peak_valid),
    .peak_mag(peak_mag), .peak_idx(peak_idx), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] re; logic [31:0] im; logic last; logic [31:0] mag; } vec_t;
  typedef struct { logic [31:0] mag; logic [7:0] idx; logic nan; } pkv_t;
  typedef struct { logic [31:0] mag; logic [7:0] idx; logic last; int cyc; bit tchk; } orec_t;
  typedef struct { logic [31:0] mag; logic [7:0] idx; logic nan; int cyc; } prec_t;

  int     n_chk = 0, n_pass = 0, cyc = 0, n_acc = 0, hold_err = 0, ready_mode = 1;
  orec_t  exp_out[$], got_out[$];
  prec_t  exp_pk[$], got_pk[$];
  longint fr_val[$];
  bit     fr_nan[$];
  int     m_idx = 0;
  bit     tchk_en = 0;

  function automatic void chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endfunction

  function automatic logic [31:0] int2fp(input longint v);
    int     p = 0;
    longint fr;
    if (v == 0) return 32'h0;
    for (int i = 0; i < 40; i++) if (((v >> i) & 1) != 0) p = i;
    fr = (v << (23 - p)) & 64'h7F_FFFF;
    return {1'b0, 8'(127 + p), 23'(fr)};
  endfunction

  function automatic logic [31:0] mkfp(input int v);
    logic [31:0] t;
    t = int2fp(longint'(v < 0 ? -v : v));
    if (v < 0) t[31] = 1'b1;
    return t;
  endfunction

  function automatic longint fp2int(input logic [31:0] f);
    int     e = int'(f[30:23]);
    longint m = longint'({1'b1, f[22:0]});
    if (e == 0) return 0;
    return (e >= 150) ? (m << (e - 150)) : (m >> (150 - e));
  endfunction

  // Reference: magnitude from integer parts; frame peak = earliest strict maximum of non-NaN values.
  function automatic void model_accept(input logic [31:0] re, input logic [31:0] im,
                                       input logic lst, input int c);
    bit     nan = (re[30:23] == 8'hFF && re[22:0] != 0) || (im[30:23] == 8'hFF && im[22:0] != 0);
    longint a = fp2int(re), b = fp2int(im);
    longint v = a * a + b * b;
    logic   fe = lst || (m_idx == 255);
    int     best = -1;
    exp_out.push_back('{nan ? 32'h7FC0_0000 : int2fp(v), 8'(m_idx), fe, c + 15, tchk_en});
    fr_val.push_back(v);
    fr_nan.push_back(nan);
    if (fe) begin
      bit any_nan = 0;
      foreach (fr_val[i]) begin
        if (fr_nan[i]) any_nan = 1;
        else if (best < 0 || fr_val[i] > fr_val[best]) best = i;
      end
      exp_pk.push_back('{best < 0 ? 32'h0 : int2fp(fr_val[best]), 8'(best < 0 ? 0 : best), any_nan, c + 15});
      fr_val.delete();
      fr_nan.delete();
      m_idx = 0;
    end else m_idx++;
  endfunction

  function automatic void model_clear();
    exp_out.delete(); got_out.delete(); exp_pk.delete(); got_pk.delete();
    fr_val.delete(); fr_nan.delete(); m_idx = 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: records accepts into the model, captures popped outputs and peak pulses.
  initial begin
    logic        prev_stall = 0;
    logic [40:0] prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (in_valid && in_ready) begin
          model_accept(in_re, in_im, in_last, cyc);
          n_acc++;
        end
        if (prev_stall && ({out_last, out_idx, out_mag} != prev_out)) hold_err++;
        if (out_valid && out_ready) got_out.push_back('{out_mag, out_idx, out_last, cyc, 1'b0});
        if (peak_valid) got_pk.push_back('{peak_mag, peak_idx, nan_seen, cyc});
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_last, out_idx, out_mag};
      end
    end
  end

  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic lst);
    int w = 0;
    in_valid = 1'b1; in_re = re; in_im = im; in_last = lst;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("send_timeout", w, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    repeat (20) @(negedge clk);
    while ((got_out.size() != exp_out.size() || got_pk.size() != exp_pk.size() || out_valid)
           && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk({name, "_drain_timeout"}, w, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string name);
    chk({name, "_out_count"}, got_out.size(), exp_out.size());
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      chk({name, "_out"}, {got_out[i].last, got_out[i].idx, got_out[i].mag},
          {exp_out[i].last, exp_out[i].idx, exp_out[i].mag});
      if (exp_out[i].tchk) chk({name, "_out_latency"}, got_out[i].cyc, exp_out[i].cyc);
    end
    chk({name, "_peak_count"}, got_pk.size(), exp_pk.size());
    for (int i = 0; i < got_pk.size() && i < exp_pk.size(); i++) begin
      chk({name, "_peak"}, {got_pk[i].nan, got_pk[i].idx, got_pk[i].mag},
          {exp_pk[i].nan, exp_pk[i].idx, exp_pk[i].mag});
      chk({name, "_peak_latency"}, got_pk[i].cyc, exp_pk[i].cyc);
    end
    chk({name, "_out_hold"}, hold_err, 0);
    model_clear();
  endtask

  vec_t tv[8];
  pkv_t tp[3];

  initial begin
    int base;
    tv[0] = '{32'h4040_0000, 32'h4080_0000, 1'b1, 32'h41C8_0000};
    tv[1] = '{32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h3F80_0000};
    tv[2] = '{32'h4000_0000, 32'h0000_0000, 1'b0, 32'h4080_0000};
    tv[3] = '{32'hC000_0000, 32'h0000_0000, 1'b0, 32'h4080_0000};
    tv[4] = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000};
    tv[5] = '{32'h4040_0000, 32'h0000_0000, 1'b0, 32'h4110_0000};
    tv[6] = '{32'h7FC0_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000};
    tv[7] = '{32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h3F80_0000};
    tp[0] = '{32'h41C8_0000, 8'd0, 1'b0};
    tp[1] = '{32'h4080_0000, 8'd1, 1'b0};
    tp[2] = '{32'h4110_0000, 8'd0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_peak", {nan_seen, peak_idx, peak_mag}, 0);
    @(posedge clk);
    #1;

    // Directed table: single bin, four-bin tie frame, NaN frame.
    tchk_en = 1;
    for (int i = 0; i < 8; i++) send(tv[i].re, tv[i].im, tv[i].last);
    drain("dir");
    for (int i = 0; i < 8; i++) begin
      if (i < got_out.size()) chk("tbl_mag", got_out[i].mag, tv[i].mag);
      else chk("tbl_missing_out", i, got_out.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got_pk.size()) chk("tbl_peak", {got_pk[i].nan, got_pk[i].idx, got_pk[i].mag},
                                 {tp[i].nan, tp[i].idx, tp[i].mag});
      else chk("tbl_missing_peak", i, got_pk.size());
    end
    compare_model("dir");
    tchk_en = 0;

    // Backpressure: 40 bins with the consumer stalled.
    ready_mode = 0;
    base = n_acc;
    fork
      for (int i = 0; i < 40; i++) send(mkfp(i + 1), mkfp(-i), i == 39);
      begin
        repeat (60) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted", n_acc - base, 32);
        chk("bp_out_valid", out_valid, 1);
        ready_mode = 1;
      end
    join
    drain("bp");
    compare_model("bp");

    // Forced frame end after 256 bins, then one more bin.
    for (int i = 0; i < 257; i++)
      send(mkfp(int'($urandom_range(200, 0)) - 100), mkfp(int'($urandom_range(200, 0)) - 100), i == 256);
    drain("forced");
    if (got_out.size() == 257) begin
      chk("forced_last255", got_out[255].last, 1);
      chk("forced_next_idx", got_out[256].idx, 0);
    end else chk("forced_out_count", got_out.size(), 257);
    chk("forced_peak_pulses", got_pk.size(), 2);
    compare_model("forced");

    // Reset with data in the FIFO and bins in flight.
    ready_mode = 0;
    for (int i = 0; i < 10; i++) send(mkfp(i + 1), 32'h0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rm_out_valid_before", out_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(mkfp(i + 7), 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_peak_valid", peak_valid, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 1;
    hold_err = 0;
    for (int i = 0; i < 3; i++) send(mkfp(5 - i), mkfp(i), i == 2);
    drain("rm");
    if (got_out.size() > 0) chk("rm_first_idx", got_out[0].idx, 0);
    else chk("rm_no_output", got_out.size(), 3);
    compare_model("rm");

    // Random frames with idle gaps and random consumer stalls.
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      int len = 1 + int'($urandom_range(23, 0));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(3, 0) == 0) begin
          @(posedge clk);
          #1;
        end
        send(mkfp(int'($urandom_range(4094, 0)) - 2047),
             mkfp(int'($urandom_range(4094, 0)) - 2047), j == len - 1);
      end
    end
    ready_mode = 1;
    drain("rnd");
    compare_model("rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
